// File: rtl/rv_hazard_ctl.sv
// rv_hazard_ctl: hazard tracker for a three-stage back end (alu2, write, wr_back).
// It tracks the destination register of each in-flight instruction and produces
// the forwarding-mux selects for the decode stage's two sources. A source that
// depends on a load still sitting in alu2 causes a one-cycle load-use stall.
module rv_hazard_ctl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dec_vld,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic        i_rd_wr,
  input  logic        i_is_load,
  input  logic        i_stall_ext,
  input  logic        i_flush,
  output logic [2:0]  o_rs1_bp,
  output logic [2:0]  o_rs2_bp,
  output logic        o_stall,
  output logic        o_issue,
  output logic [15:0] o_stall_cnt
);

  localparam int NSLOT = 3;

  // Slot 0 = alu2 (youngest), slot 1 = write, slot 2 = wr_back (oldest).
  logic [NSLOT-1:0] vld_q, vld_d;
  logic [NSLOT-1:0] rdy_q, rdy_d;
  logic [4:0]       rd_q [NSLOT];
  logic [4:0]       rd_d [NSLOT];
  logic [15:0]      cnt_q, cnt_d;

  logic [4:0]       src [2];
  logic [1:0]       haz;
  logic             load_use;
  logic             advance;

  assign src[0] = i_rs1;
  assign src[1] = i_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [2:0] bp;
      logic       hz;

      // Youngest matching slot decides; if it is not ready, nothing older is forwarded.
      always_comb begin
        bp = 3'b000;
        hz = 1'b0;
        if (src[gi] != 5'd0) begin
          if (vld_q[0] && (rd_q[0] == src[gi])) begin
            bp = rdy_q[0] ? 3'b100 : 3'b000;
            hz = !rdy_q[0];
          end else if (vld_q[1] && (rd_q[1] == src[gi])) begin
            bp = rdy_q[1] ? 3'b010 : 3'b000;
            hz = !rdy_q[1];
          end else if (vld_q[2] && (rd_q[2] == src[gi])) begin
            bp = rdy_q[2] ? 3'b001 : 3'b000;
            hz = !rdy_q[2];
          end
        end
      end

      assign haz[gi] = hz;
    end
  endgenerate

  assign o_rs1_bp    = g_src[0].bp;
  assign o_rs2_bp    = g_src[1].bp;

  assign advance     = !i_stall_ext;
  assign load_use    = i_dec_vld && !i_flush && (|haz);
  assign o_stall     = load_use || i_stall_ext;
  assign o_issue     = i_dec_vld && !i_flush && !o_stall;
  assign o_stall_cnt = cnt_q;

  // Next slot contents: shift toward wr_back on advance, new entry or bubble into alu2.
  always_comb begin
    vld_d = vld_q;
    rdy_d = rdy_q;
    rd_d  = rd_q;
    if (advance) begin
      vld_d[2] = vld_q[1];
      rd_d[2]  = rd_q[1];
      rdy_d[2] = rdy_q[1];
      vld_d[1] = vld_q[0];
      rd_d[1]  = rd_q[0];
      rdy_d[1] = 1'b1;  // every result, including load data, is forwardable from write onward
      if (o_issue) begin
        vld_d[0] = i_rd_wr && (i_rd != 5'd0);
        rd_d[0]  = i_rd;
        rdy_d[0] = !i_is_load;
      end else begin
        vld_d[0] = 1'b0;
        rd_d[0]  = 5'd0;
        rdy_d[0] = 1'b0;
      end
    end
  end

  // Saturating load-use stall counter; frozen while the pipeline is held externally.
  always_comb begin
    cnt_d = cnt_q;
    if (load_use && advance && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_q <= '0;
      rdy_q <= '0;
      rd_q  <= '{default: 5'd0};
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rdy_q <= rdy_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_hazard_ctl.sv
// Directed bench for rv_hazard_ctl: linear sequence of steps with hand-computed expectations.
module tb_rv_hazard_ctl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_dec_vld;
  logic [4:0]  i_rs1, i_rs2, i_rd;
  logic        i_rd_wr, i_is_load, i_stall_ext, i_flush;
  logic [2:0]  o_rs1_bp, o_rs2_bp;
  logic        o_stall, o_issue;
  logic [15:0] o_stall_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  rv_hazard_ctl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_dec_vld   (i_dec_vld),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_rd        (i_rd),
    .i_rd_wr     (i_rd_wr),
    .i_is_load   (i_is_load),
    .i_stall_ext (i_stall_ext),
    .i_flush     (i_flush),
    .o_rs1_bp    (o_rs1_bp),
    .o_rs2_bp    (o_rs2_bp),
    .o_stall     (o_stall),
    .o_issue     (o_issue),
    .o_stall_cnt (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive decode fields: valid, rs1, rs2, rd, rd_wr, is_load.
  task automatic dec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] d, input logic w, input logic ld);
    i_dec_vld = v; i_rs1 = r1; i_rs2 = r2; i_rd = d; i_rd_wr = w; i_is_load = ld;
    #2;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic show(input string step);
    $display("%-28s rs1_bp=%b rs2_bp=%b stall=%b issue=%b cnt=%h",
             step, o_rs1_bp, o_rs2_bp, o_stall, o_issue, o_stall_cnt);
  endtask

  initial begin
    int  cyc;
    int  seen_stall;

    // ---------------- reset state ----------------
    i_reset = 1'b1; i_stall_ext = 1'b0; i_flush = 1'b0;
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    show("reset");
    check("rst_rs1_bp", {13'd0, o_rs1_bp}, 16'h0);
    check("rst_rs2_bp", {13'd0, o_rs2_bp}, 16'h0);
    check("rst_stall",  {15'd0, o_stall},  16'h0);
    check("rst_issue",  {15'd0, o_issue},  16'h0);
    check("rst_cnt",    o_stall_cnt,       16'h0);
    i_stall_ext = 1'b1; #1;
    check("rst_stall_follows_ext", {15'd0, o_stall}, 16'h1);
    i_stall_ext = 1'b0;
    tick();
    i_reset = 1'b0;

    // ---------------- ALU chain on x5 ----------------
    dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);            // ADD x5
    show("issue ADD x5");
    check("alu_issue", {15'd0, o_issue}, 16'h1);
    tick();
    dec(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);            // reader, writes nothing
    show("rs1=x5 (alu2)");
    check("alu_bp_s0", {13'd0, o_rs1_bp}, 16'h4);
    check("alu_stall", {15'd0, o_stall},  16'h0);
    tick();
    show("rs1=x5 (write)");
    check("alu_bp_s1", {13'd0, o_rs1_bp}, 16'h2);
    tick();
    show("rs1=x5 (wr_back)");
    check("alu_bp_s2", {13'd0, o_rs1_bp}, 16'h1);
    tick();
    show("rs1=x5 (retired)");
    check("alu_bp_none", {13'd0, o_rs1_bp}, 16'h0);
    tick();

    // ---------------- load-use on x7 ----------------
    dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);            // LW x7
    show("issue LW x7");
    check("lw_issue", {15'd0, o_issue}, 16'h1);
    tick();
    dec(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);            // use x7 on rs2
    show("rs2=x7 load-use");
    check("lu_stall",  {15'd0, o_stall},  16'h1);
    check("lu_issue",  {15'd0, o_issue},  16'h0);
    check("lu_rs2_bp", {13'd0, o_rs2_bp}, 16'h0);
    tick();
    show("rs2=x7 after stall");
    check("lu_cnt1",     o_stall_cnt,       16'h1);
    check("lu_stall_off",{15'd0, o_stall},  16'h0);
    check("lu_bp_s1",    {13'd0, o_rs2_bp}, 16'h2);
    check("lu_issue2",   {15'd0, o_issue},  16'h1);
    tick();

    // ---------------- priority ----------------
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();   // ADD x3
    dec(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0); tick();   // ADD x4
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();   // ADD x3 (S0), x4 (S1), x3 (S2)
    dec(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    show("prio x3 S0+S2");
    check("prio_rs1_s0", {13'd0, o_rs1_bp}, 16'h4);
    check("prio_rs2_s1", {13'd0, o_rs2_bp}, 16'h2);
    tick();                                              // bubble-like entry (no rd)
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();   // ADD x3
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1); tick();   // LW x3: S0 load x3, S1 x3
    dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    show("prio load x3 S0, x3 S1");
    check("prio_load_bp",    {13'd0, o_rs1_bp}, 16'h0);
    check("prio_load_stall", {15'd0, o_stall},  16'h1);
    tick();
    show("prio after stall");
    check("prio_after_bp", {13'd0, o_rs1_bp}, 16'h2);
    check("prio_cnt2",     o_stall_cnt,       16'h2);
    tick();

    // ---------------- x0 ----------------
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);            // LW x0: never tracked
    tick();
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    show("x0 sources");
    check("x0_rs1_bp", {13'd0, o_rs1_bp}, 16'h0);
    check("x0_rs2_bp", {13'd0, o_rs2_bp}, 16'h0);
    check("x0_stall",  {15'd0, o_stall},  16'h0);
    tick();

    // ---------------- external stall freeze ----------------
    dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);            // ADD x9
    tick();
    i_stall_ext = 1'b1;
    dec(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      show("ext stall rs1=x9");
      check("ext_bp_hold", {13'd0, o_rs1_bp}, 16'h4);
      check("ext_stall",   {15'd0, o_stall},  16'h1);
      check("ext_issue",   {15'd0, o_issue},  16'h0);
      tick();
    end
    i_stall_ext = 1'b0; #1;
    show("ext released");
    check("ext_frozen_bp", {13'd0, o_rs1_bp}, 16'h4);
    check("ext_issue_rel", {15'd0, o_issue},  16'h1);
    check("ext_cnt",       o_stall_cnt,       16'h2);
    tick();

    // Load-use under external stall does not count; flush clears the hazard.
    dec(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1); tick();  // LW x10
    i_stall_ext = 1'b1;
    dec(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    check("ext_lu_cnt", o_stall_cnt, 16'h2);
    i_flush = 1'b1; #1;
    show("flush + ext stall");
    check("fl_ext_stall", {15'd0, o_stall}, 16'h1);
    check("fl_ext_issue", {15'd0, o_issue}, 16'h0);
    tick();                                              // slots hold: load still in S0
    i_stall_ext = 1'b0; #1;
    show("flush, load pending");
    check("fl_stall", {15'd0, o_stall}, 16'h0);
    check("fl_issue", {15'd0, o_issue}, 16'h0);
    tick();
    check("fl_cnt", o_stall_cnt, 16'h2);
    i_flush = 1'b0; #1;
    show("after flush rs1=x10");
    check("fl_bp_s1", {13'd0, o_rs1_bp}, 16'h2);
    tick();

    // ---------------- saturation ----------------
    // Self-dependent load held in decode: alternates stall / issue every cycle.
    dec(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1);
    cyc = 0;
    while (o_stall_cnt != 16'hFFFE && cyc < 140000) begin
      tick();
      cyc++;
    end
    show("preload");
    check("sat_preload", o_stall_cnt, 16'hFFFE);
    seen_stall = 0;
    cyc = 0;
    while (seen_stall < 2 && cyc < 8) begin
      if (o_stall) seen_stall++;
      tick();
      cyc++;
    end
    show("two more stalls");
    check("sat_two_stalls", seen_stall[15:0], 16'd2);
    check("sat_ffff", o_stall_cnt, 16'hFFFF);
    for (int k = 0; k < 6; k++) tick();
    check("sat_hold", o_stall_cnt, 16'hFFFF);

    // Reset in the middle of a load-use stall.
    cyc = 0;
    while (!o_stall && cyc < 4) begin
      tick();
      cyc++;
    end
    check("rst_mid_stall_pre", {15'd0, o_stall}, 16'h1);
    i_reset = 1'b1; #1;
    show("reset mid-stall");
    check("rmid_cnt",   o_stall_cnt,       16'h0);
    check("rmid_bp",    {13'd0, o_rs1_bp}, 16'h0);
    check("rmid_stall", {15'd0, o_stall},  16'h0);
    check("rmid_issue", {15'd0, o_issue},  16'h1);
    tick();
    i_reset = 1'b0; #1;
    show("first post-reset cycle");
    check("post_rst_stall", {15'd0, o_stall}, 16'h0);
    check("post_rst_issue", {15'd0, o_issue}, 16'h1);
    tick();
    show("post-reset load-use");
    check("post_rst_lu", {15'd0, o_stall}, 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
